// File: rtl/dmem_dump_pkg.sv
// Shared types for the post-run data-memory dump block.
package dmem_dump_pkg;

    typedef enum logic [2:0] {
        DUMP_IDLE,
        DUMP_READ,
        DUMP_WAIT,
        DUMP_SEND,
        DUMP_FIN
    } dump_state_t;

    localparam int DUMP_DATA_W = 8;

endpackage

// File: rtl/dmem_dump_if.sv
// Data-memory read port plus valid/ready byte stream used by dmem_dump.
// master = the dumper, slave = memory/sink side.
interface dmem_dump_if #(
    parameter int ADDR_W = 8
);
    logic              dm_rd_en;
    logic [ADDR_W-1:0] dm_rd_addr;
    logic [7:0]        dm_rd_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;

    modport master (
        output dm_rd_en, dm_rd_addr, tx_data, tx_valid, tx_last,
        input  dm_rd_data, tx_ready
    );

    modport slave (
        input  dm_rd_en, dm_rd_addr, tx_data, tx_valid, tx_last,
        output dm_rd_data, tx_ready
    );
endinterface

// File: rtl/dmem_dump.sv
// Drains a window of data memory over a byte stream once the core halts.
// DMEM_DUMP_CHECKSUM_EN appends a mod-256 sum byte after the data bytes.
//
// state | meaning
// IDLE  | waiting for core done, outputs quiet
// READ  | read strobe for the current index
// WAIT  | memory data arrives, captured into the tx register
// SEND  | byte presented until the sink accepts it
// FIN   | dump complete, sticky until start
module dmem_dump
    import dmem_dump_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BASE   = 0,
    parameter int COUNT  = 5
) (
    input  logic             clk,
    input  logic             start,
    input  logic             done,
    dmem_dump_if.master      bus,
    output logic             busy,
    output logic             dump_done
);

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(COUNT - 1);
    localparam logic              EMPTY    = (COUNT == 0);

    dump_state_t       state_q, state_d;
    logic [ADDR_W:0]   idx_q;
    logic [7:0]        data_q;
    logic              hs;
    logic              at_last;

`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [7:0]        sum_q;
    logic              chk_q;
`endif

    assign hs      = (state_q == DUMP_SEND) && bus.tx_ready;
    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d        = state_q;
        bus.dm_rd_en   = 1'b0;
        bus.dm_rd_addr = '0;
        bus.tx_valid   = 1'b0;
        bus.tx_data    = '0;
        bus.tx_last    = 1'b0;
        busy           = 1'b0;
        dump_done      = 1'b0;

        case (state_q)
            DUMP_IDLE: begin
                if (done) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                    state_d = EMPTY ? DUMP_SEND : DUMP_READ;
`else
                    state_d = EMPTY ? DUMP_FIN : DUMP_READ;
`endif
                end
            end
            DUMP_READ: begin
                bus.dm_rd_en   = 1'b1;
                bus.dm_rd_addr = BASE_A + idx_q[ADDR_W-1:0];
                busy           = 1'b1;
                state_d        = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                busy    = 1'b1;
                state_d = DUMP_SEND;
            end
            DUMP_SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = data_q;
                busy         = 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
                bus.tx_last  = chk_q;
                if (hs) begin
                    if (chk_q)        state_d = DUMP_FIN;
                    else if (at_last) state_d = DUMP_SEND;
                    else              state_d = DUMP_READ;
                end
`else
                bus.tx_last  = at_last;
                if (hs) state_d = at_last ? DUMP_FIN : DUMP_READ;
`endif
            end
            DUMP_FIN: begin
                dump_done = 1'b1;
            end
            default: state_d = DUMP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (start) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            sum_q   <= '0;
            chk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                DUMP_IDLE: begin
                    if (done) begin
                        idx_q  <= '0;
                        data_q <= '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
                        sum_q  <= '0;
                        // an empty window goes straight to the (zero) checksum byte
                        chk_q  <= EMPTY;
`endif
                    end
                end
                DUMP_WAIT: data_q <= bus.dm_rd_data;
                DUMP_SEND: begin
                    if (hs) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                        if (!chk_q) begin
                            idx_q <= idx_q + 1'b1;
                            sum_q <= sum_q + data_q;
                            if (at_last) begin
                                data_q <= sum_q + data_q;
                                chk_q  <= 1'b1;
                            end
                        end
`else
                        idx_q <= idx_q + 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dump.sv
// Self-checking bench for dmem_dump: cycle table for the standard dump plus
// hand sequences for wrap, empty window, backpressure and mid-dump reset.
module tb_dmem_dump;

`ifdef DMEM_DUMP_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic start, done;
    logic busy_a, dd_a, busy_b, dd_b, busy_c, dd_c;

    dmem_dump_if #(.ADDR_W(8)) bus_a ();
    dmem_dump_if #(.ADDR_W(8)) bus_b ();
    dmem_dump_if #(.ADDR_W(8)) bus_c ();

    dmem_dump #(.ADDR_W(8), .BASE(0), .COUNT(5)) dut_a (
        .clk(clk), .start(start), .done(done), .bus(bus_a), .busy(busy_a), .dump_done(dd_a));
    dmem_dump #(.ADDR_W(8), .BASE(254), .COUNT(3)) dut_b (
        .clk(clk), .start(start), .done(done), .bus(bus_b), .busy(busy_b), .dump_done(dd_b));
    dmem_dump #(.ADDR_W(8), .BASE(0), .COUNT(0)) dut_c (
        .clk(clk), .start(start), .done(done), .bus(bus_c), .busy(busy_c), .dump_done(dd_c));

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    always @(posedge clk) begin
        if (bus_a.dm_rd_en) bus_a.dm_rd_data <= mem_a[bus_a.dm_rd_addr];
        if (bus_b.dm_rd_en) bus_b.dm_rd_data <= mem_b[bus_b.dm_rd_addr];
        if (bus_c.dm_rd_en) bus_c.dm_rd_data <= 8'hEE;
    end

    // stream/read monitors: {last, data} per accepted byte, address per read
    logic [8:0] q_a[$], q_b[$], q_c[$];
    logic [7:0] addr_a[$], addr_b[$], addr_c[$];

    always @(negedge clk) begin
        if (bus_a.tx_valid && bus_a.tx_ready) q_a.push_back({bus_a.tx_last, bus_a.tx_data});
        if (bus_b.tx_valid && bus_b.tx_ready) q_b.push_back({bus_b.tx_last, bus_b.tx_data});
        if (bus_c.tx_valid && bus_c.tx_ready) q_c.push_back({bus_c.tx_last, bus_c.tx_data});
        if (bus_a.dm_rd_en) addr_a.push_back(bus_a.dm_rd_addr);
        if (bus_b.dm_rd_en) addr_b.push_back(bus_b.dm_rd_addr);
        if (bus_c.dm_rd_en) addr_c.push_back(bus_c.dm_rd_addr);
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_stream(input string nm, input logic [8:0] got[$], input logic [8:0] exp[$]);
        chk({nm, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), (i < got.size()) ? got[i] : 9'h1FF, exp[i]);
    endtask

    task automatic clear_mon();
        q_a.delete(); q_b.delete(); q_c.delete();
        addr_a.delete(); addr_b.delete(); addr_c.delete();
    endtask

    typedef struct {
        logic       rdy;
        logic       rd_en;
        logic [7:0] addr;
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       busy;
        logic       dd;
    } vec_t;

    function automatic vec_t v(input logic r, input logic re, input logic [7:0] ad,
                               input logic vl, input logic [7:0] d, input logic l,
                               input logic b, input logic dd);
        return '{rdy: r, rd_en: re, addr: ad, valid: vl, data: d, last: l, busy: b, dd: dd};
    endfunction

    vec_t tv[$];
    logic [8:0] exp_a[$], exp_b[$], exp_c[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_first;

        foreach (mem_a[i]) begin mem_a[i] = 8'hA5; mem_b[i] = 8'h5A; end
        mem_a[0] = 8'h0F; mem_a[1] = 8'h0C; mem_a[2] = 8'h00; mem_a[3] = 8'h1B; mem_a[4] = 8'hFA;
        mem_b[8'hFE] = 8'h11; mem_b[8'hFF] = 8'h22; mem_b[8'h00] = 8'h33;

        if (CHK) begin
            exp_a = '{9'h00F, 9'h00C, 9'h000, 9'h01B, 9'h0FA, 9'h130};
            exp_b = '{9'h011, 9'h022, 9'h033, 9'h166};
            exp_c = '{9'h100};
        end else begin
            exp_a = '{9'h00F, 9'h00C, 9'h000, 9'h01B, 9'h1FA};
            exp_b = '{9'h011, 9'h022, 9'h133};
            exp_c.delete();
        end

        // cycle-by-cycle expectation for the standard dump, cycle 1 = first after done edge
        tv.push_back(v(1, 1, 8'h00, 0, 8'h00, 0, 1, 0));
        tv.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 1, 0));
        tv.push_back(v(1, 0, 8'h00, 1, 8'h0F, 0, 1, 0));
        tv.push_back(v(1, 1, 8'h01, 0, 8'h00, 0, 1, 0));
        tv.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 1, 0));
        tv.push_back(v(1, 0, 8'h00, 1, 8'h0C, 0, 1, 0));
        tv.push_back(v(1, 1, 8'h02, 0, 8'h00, 0, 1, 0));
        tv.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 1, 0));
        tv.push_back(v(1, 0, 8'h00, 1, 8'h00, 0, 1, 0));
        tv.push_back(v(1, 1, 8'h03, 0, 8'h00, 0, 1, 0));
        tv.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 1, 0));
        tv.push_back(v(1, 0, 8'h00, 1, 8'h1B, 0, 1, 0));
        tv.push_back(v(1, 1, 8'h04, 0, 8'h00, 0, 1, 0));
        tv.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 1, 0));
        tv.push_back(v(1, 0, 8'h00, 1, 8'hFA, !CHK, 1, 0));
        if (CHK) tv.push_back(v(1, 0, 8'h00, 1, 8'h30, 1, 1, 0));
        tv.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 1));
        tv.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 0, 1));
        tv.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 1));
        tv.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 0, 1));

        // reset with done already high: reset must win
        start = 1'b1; done = 1'b1;
        bus_a.tx_ready = 1'b1; bus_b.tx_ready = 1'b1; bus_c.tx_ready = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", bus_a.dm_rd_en, 0);
        chk("rst_valid", bus_a.tx_valid, 0);
        chk("rst_data",  bus_a.tx_data, 0);
        chk("rst_last",  bus_a.tx_last, 0);
        chk("rst_busy",  busy_a, 0);
        chk("rst_dd",    dd_a, 0);
        chk("rst_c_dd",  dd_c, 0);
        clear_mon();
        @(posedge clk); #1;
        start = 1'b0;

        c_first = 0;
        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk); #1;
            bus_a.tx_ready = tv[i].rdy;
            @(negedge clk);
            chk($sformatf("tv%0d_rd_en", i + 1), bus_a.dm_rd_en, tv[i].rd_en);
            if (tv[i].rd_en) chk($sformatf("tv%0d_addr", i + 1), bus_a.dm_rd_addr, tv[i].addr);
            chk($sformatf("tv%0d_valid", i + 1), bus_a.tx_valid, tv[i].valid);
            chk($sformatf("tv%0d_data", i + 1),  bus_a.tx_data, tv[i].data);
            chk($sformatf("tv%0d_last", i + 1),  bus_a.tx_last, tv[i].last);
            chk($sformatf("tv%0d_busy", i + 1),  busy_a, tv[i].busy);
            chk($sformatf("tv%0d_dd", i + 1),    dd_a, tv[i].dd);
            if (dd_c && c_first == 0) c_first = i + 1;
        end

        chk_stream("std_stream", q_a, exp_a);
        chk_stream("wrap_stream", q_b, exp_b);
        chk("wrap_reads", addr_b.size(), 3);
        chk("wrap_addr0", addr_b.size() > 0 ? addr_b[0] : 8'h99, 8'hFE);
        chk("wrap_addr1", addr_b.size() > 1 ? addr_b[1] : 8'h99, 8'hFF);
        chk("wrap_addr2", addr_b.size() > 2 ? addr_b[2] : 8'h99, 8'h00);
        chk("wrap_dd", dd_b, 1);
        chk_stream("empty_stream", q_c, exp_c);
        chk("empty_reads", addr_c.size(), 0);
        chk("empty_dd_cycle", c_first, CHK ? 2 : 1);

        // backpressure on byte 1
        @(posedge clk); #1; start = 1'b1; done = 1'b0;
        @(posedge clk); #1; start = 1'b0; done = 1'b1; bus_a.tx_ready = 1'b1;
        clear_mon();
        repeat (4) @(posedge clk);
        #1; bus_a.tx_ready = 1'b0;
        for (int k = 0; k < 10 && !bus_a.tx_valid; k++) @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("bp_valid%0d", k), bus_a.tx_valid, 1);
            chk($sformatf("bp_data%0d", k), bus_a.tx_data, 8'h0C);
            chk($sformatf("bp_rd_en%0d", k), bus_a.dm_rd_en, 0);
        end
        chk("bp_reads_held", addr_a.size(), 2);
        @(posedge clk); #1; bus_a.tx_ready = 1'b1;
        for (int k = 0; k < 60 && !dd_a; k++) @(negedge clk);
        chk("bp_finish", dd_a, 1);
        chk_stream("bp_stream", q_a, exp_a);
        chk("bp_reads", addr_a.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("bp_addr%0d", i), i < addr_a.size() ? addr_a[i] : 8'h99, i);

        // reset while byte 2 is being presented, then a full re-dump
        @(posedge clk); #1; start = 1'b1; done = 1'b0;
        @(posedge clk); #1; start = 1'b0; done = 1'b1; bus_a.tx_ready = 1'b1;
        clear_mon();
        for (int k = 0; k < 30 && !(bus_a.tx_valid && bus_a.tx_data == 8'h0C); k++) @(negedge clk);
        chk("mid_seen_b1", bus_a.tx_data, 8'h0C);
        @(posedge clk); #1; bus_a.tx_ready = 1'b0;
        for (int k = 0; k < 10 && !bus_a.tx_valid; k++) @(negedge clk);
        chk("mid_b2_data", bus_a.tx_data, 8'h00);
        @(posedge clk); #1; start = 1'b1;
        clear_mon();
        @(posedge clk); @(negedge clk);
        chk("mid_valid_drop", bus_a.tx_valid, 0);
        chk("mid_busy_drop", busy_a, 0);
        chk("mid_data_zero", bus_a.tx_data, 0);
        @(posedge clk); #1; start = 1'b0; bus_a.tx_ready = 1'b1;
        for (int k = 0; k < 60 && !dd_a; k++) @(negedge clk);
        chk("mid_finish", dd_a, 1);
        chk_stream("mid_stream", q_a, exp_a);
        chk("mid_first_addr", addr_a.size() > 0 ? addr_a[0] : 8'h99, 8'h00);

        // done stays high after completion: no second dump
        repeat (10) @(negedge clk);
        chk("hold_dd", dd_a, 1);
        chk("hold_busy", busy_a, 0);
        chk("hold_reads", addr_a.size(), 5);
        chk("hold_bytes", q_a.size(), exp_a.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
